// File: rtl/pkt_pkg.sv
// Constants and types shared by the packet framer and the switch core it feeds.
package pkt_pkg;

  localparam int unsigned LEN_W       = 10;
  localparam int unsigned DEF_MIN_LEN = 64;
  localparam int unsigned DEF_MAX_LEN = 512;

  localparam logic [7:0] HDR_B0 = 8'h55;
  localparam logic [7:0] HDR_B1 = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_PAD,
    ST_DRAIN,
    ST_GAP
  } framer_state_t;

  function automatic logic [LEN_W-1:0] len_min(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [LEN_W-1:0] len_max(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pkt_framer.sv
// Frames a valid/ready byte stream as 55 D5 + payload, padding to a minimum,
// truncating at a maximum and holding rx_vld low for an idle gap between frames.
module pkt_framer
  import pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN       = DEF_MAX_LEN,
  parameter int unsigned MIN_LEN_FLOOR = DEF_MIN_LEN,
  parameter int unsigned GAP_CYC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LEN_W-1:0] min_len,
  input  logic [LEN_W-1:0] max_len,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [7:0]       rxd,
  output logic             rx_vld,
  output logic             busy,
  output logic             pkt_done,
  output logic             trunc,
  output logic             underrun,
  output logic [15:0]      pkt_cnt
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  framer_state_t    r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_smin;
  logic [LEN_W-1:0] r_smax;
  logic [GAP_W-1:0] r_gap;
  logic             r_s_ready;
  logic [7:0]       r_rxd;
  logic             r_rx_vld;
  logic             r_busy;
  logic             r_pkt_done;
  logic             r_trunc;
  logic             r_underrun;
  logic [15:0]      r_pkt_cnt;

  logic [LEN_W-1:0] w_smax;
  logic [LEN_W-1:0] w_smin;
  logic [LEN_W-1:0] w_cnt_inc;

  // Shadow limits: max clamped to the ceiling, min floored then capped by max.
  assign w_smax    = len_min(max_len, LEN_W'(MAX_LEN));
  assign w_smin    = len_min(len_max(min_len, LEN_W'(MIN_LEN_FLOOR)), w_smax);
  assign w_cnt_inc = r_cnt + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_smin     <= '0;
      r_smax     <= '0;
      r_gap      <= '0;
      r_s_ready  <= 1'b0;
      r_rxd      <= '0;
      r_rx_vld   <= 1'b0;
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
      r_trunc    <= 1'b0;
      r_underrun <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_rxd      <= '0;
      r_rx_vld   <= 1'b0;
      r_pkt_done <= 1'b0;
      r_trunc    <= 1'b0;
      r_underrun <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (en && s_valid) begin
            r_smax  <= w_smax;
            r_smin  <= w_smin;
            r_busy  <= 1'b1;
            r_state <= ST_HDR0;
          end
        end

        ST_HDR0: begin
          r_rxd    <= HDR_B0;
          r_rx_vld <= 1'b1;
          r_cnt    <= LEN_W'(1);
          r_state  <= ST_HDR1;
        end

        ST_HDR1: begin
          r_rxd     <= HDR_B1;
          r_rx_vld  <= 1'b1;
          r_cnt     <= LEN_W'(2);
          r_s_ready <= 1'b1;
          r_state   <= ST_PAYLOAD;
        end

        ST_PAYLOAD: begin
          if (s_valid) begin
            r_rxd    <= s_data;
            r_rx_vld <= 1'b1;
            r_cnt    <= w_cnt_inc;
            if (s_last) begin
              r_s_ready <= 1'b0;
              if (w_cnt_inc < r_smin) begin
                r_state <= ST_PAD;
              end else begin
                r_pkt_done <= 1'b1;
                r_pkt_cnt  <= r_pkt_cnt + 16'd1;
                r_gap      <= '0;
                r_state    <= ST_GAP;
              end
            end else if (w_cnt_inc >= r_smax) begin
              r_pkt_done <= 1'b1;
              r_trunc    <= 1'b1;
              r_pkt_cnt  <= r_pkt_cnt + 16'd1;
              r_state    <= ST_DRAIN;
            end
          end else begin
            // Stream starved mid-frame: abandon it and swallow the rest.
            r_underrun <= 1'b1;
            r_state    <= ST_DRAIN;
          end
        end

        ST_PAD: begin
          r_rx_vld <= 1'b1;
          r_cnt    <= w_cnt_inc;
          if (w_cnt_inc >= r_smin) begin
            r_pkt_done <= 1'b1;
            r_pkt_cnt  <= r_pkt_cnt + 16'd1;
            r_gap      <= '0;
            r_state    <= ST_GAP;
          end
        end

        ST_DRAIN: begin
          if (s_valid && s_last) begin
            r_s_ready <= 1'b0;
            r_gap     <= '0;
            r_state   <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (r_gap == GAP_W'(GAP_CYC - 1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end

        default: begin
          r_s_ready <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready  = r_s_ready;
  assign rxd      = r_rxd;
  assign rx_vld   = r_rx_vld;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;
  assign trunc    = r_trunc;
  assign underrun = r_underrun;
  assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_framer.sv
// Self-checking bench for pkt_framer: table vectors, hand-written corner
// sequences and randomized back-to-back packets scored against a frame model.
module tb_pkt_framer;

  localparam int GAP_CYC = 4;

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct packed {
    logic [15:0] len;
    logic        tr;
    logic        und;
  } desc_t;

  typedef struct {
    int n;
    int minl;
    int maxl;
    int drop;
    int exp_len;
    bit exp_tr;
    bit exp_un;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [9:0]  min_len;
  logic [9:0]  max_len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  rxd;
  logic        rx_vld;
  logic        busy;
  logic        pkt_done;
  logic        trunc;
  logic        underrun;
  logic [15:0] pkt_cnt;

  pkt_framer dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .min_len  (min_len),
    .max_len  (max_len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .rxd      (rxd),
    .rx_vld   (rx_vld),
    .busy     (busy),
    .pkt_done (pkt_done),
    .trunc    (trunc),
    .underrun (underrun),
    .pkt_cnt  (pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  int         n_checks;
  int         n_fail;
  beat_t      stream[$];
  desc_t      exp_desc[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] pay[$];
  logic [7:0] got_q[$];
  int         low_run;
  int         frames_ended;
  int         beat_cnt;
  int         rxd_nz_err;
  int         exp_cnt;
  bit         in_frame;
  bit         mon_en;

  task automatic chk(input string name, input bit ok, input int got, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: what a packet of n bytes becomes under the length rules.
  function automatic void model(input int n, input int minl, input int maxl, input int drop,
                                output int len, output bit tr, output bit un);
    int smax;
    int smin;
    smax = (maxl > 512) ? 512 : maxl;
    smin = (minl < 64) ? 64 : minl;
    if (smin > smax) smin = smax;
    tr = 1'b0;
    un = 1'b0;
    if (drop > 0) begin
      un  = 1'b1;
      len = drop + 2;
    end else if (n + 2 > smax) begin
      tr  = 1'b1;
      len = smax;
    end else begin
      len = (n + 2 < smin) ? smin : n + 2;
    end
  endfunction

  task automatic push_stream(input int drop);
    beat_t b;
    for (int i = 0; i < pay.size(); i++) begin
      if (drop > 0 && i == drop) begin
        b = '0;
        stream.push_back(b);
      end
      b.vld  = 1'b1;
      b.last = (i == pay.size() - 1);
      b.data = pay[i];
      stream.push_back(b);
    end
  endtask

  task automatic push_exp(input int len, input bit tr, input bit un);
    desc_t d;
    d.len = 16'(len);
    d.tr  = tr;
    d.und = un;
    exp_desc.push_back(d);
    for (int i = 0; i < len; i++) begin
      if (i == 0) exp_bytes.push_back(8'h55);
      else if (i == 1) exp_bytes.push_back(8'hD5);
      else if (i - 2 < pay.size()) exp_bytes.push_back(pay[i-2]);
      else exp_bytes.push_back(8'h00);
    end
  endtask

  task automatic fill_count(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'(i + 1));
  endtask

  task automatic fill_rand(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((stream.size() != 0 || busy || exp_desc.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    chk(name, k < budget, k, budget);
  endtask

  task automatic end_frame(input bit is_und, input bit is_tr);
    desc_t      d;
    int         bad;
    logic [7:0] eb;
    if (exp_desc.size() == 0) begin
      chk("unexpected_frame", 1'b0, got_q.size(), 0);
    end else begin
      d = exp_desc.pop_front();
      chk("frame_len", got_q.size() == int'(d.len), got_q.size(), int'(d.len));
      bad = 0;
      for (int i = 0; i < int'(d.len); i++) begin
        eb = 8'h00;
        if (exp_bytes.size() > 0) eb = exp_bytes.pop_front();
        if (i >= got_q.size()) bad++;
        else if (got_q[i] != eb) bad++;
      end
      chk("frame_bytes", bad == 0, bad, 0);
      chk("trunc_flag", is_tr == d.tr, int'(is_tr), int'(d.tr));
      chk("underrun_flag", is_und == d.und, int'(is_und), int'(d.und));
      if (!d.und) exp_cnt = (exp_cnt + 1) & 16'hFFFF;
      chk("pkt_cnt", pkt_cnt == 16'(exp_cnt), int'(pkt_cnt), exp_cnt);
    end
    got_q.delete();
    in_frame = 1'b0;
    frames_ended++;
  endtask

  // Monitor: rebuilds frames from the rx side away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (!rx_vld && rxd != 8'h00) rxd_nz_err++;
      if (rx_vld) begin
        if (!in_frame && frames_ended > 0)
          chk("idle_gap", low_run >= GAP_CYC, low_run, GAP_CYC);
        in_frame = 1'b1;
        got_q.push_back(rxd);
        beat_cnt++;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (underrun) begin
        chk("vld_after_underrun", !rx_vld, int'(rx_vld), 0);
        end_frame(1'b1, trunc);
      end else if (pkt_done) begin
        chk("done_on_byte", rx_vld, int'(rx_vld), 1);
        end_frame(1'b0, trunc);
      end
    end
  end

  // Driver: presents the head of the stream; an entry leaves when offered during s_ready.
  bit rdy;
  bit presented;
  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    rdy = 1'b0;
    presented = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (presented && rdy && stream.size() > 0) void'(stream.pop_front());
      presented = (stream.size() > 0);
      if (presented) begin
        s_valid = stream[0].vld;
        s_data  = stream[0].data;
        s_last  = stream[0].last;
      end else begin
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
      end
      rdy = s_ready;
    end
  end

  vec_t tbl[14] = '{
    '{100, 64,  512, 0,  102, 1'b0, 1'b0},
    '{10,  64,  512, 0,  64,  1'b0, 1'b0},
    '{600, 64,  512, 0,  512, 1'b1, 1'b0},
    '{40,  64,  512, 20, 22,  1'b0, 1'b1},
    '{510, 64,  512, 0,  512, 1'b0, 1'b0},
    '{511, 64,  512, 0,  512, 1'b1, 1'b0},
    '{10,  10,  512, 0,  64,  1'b0, 1'b0},
    '{10,  600, 512, 0,  512, 1'b0, 1'b0},
    '{50,  100, 80,  0,  80,  1'b0, 1'b0},
    '{100, 64,  80,  0,  80,  1'b1, 1'b0},
    '{62,  64,  512, 0,  64,  1'b0, 1'b0},
    '{63,  64,  512, 0,  65,  1'b0, 1'b0},
    '{1,   0,   512, 0,  64,  1'b0, 1'b0},
    '{520, 64,  1000, 0, 512, 1'b1, 1'b0}
  };

  initial begin
    int k;
    int b0;
    n_checks = 0;
    n_fail = 0;
    low_run = 0;
    frames_ended = 0;
    beat_cnt = 0;
    rxd_nz_err = 0;
    exp_cnt = 0;
    in_frame = 1'b0;
    mon_en = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    min_len = 10'd64;
    max_len = 10'd512;
    repeat (3) tick();

    chk("rst_rxd", rxd == 8'h00, int'(rxd), 0);
    chk("rst_rx_vld", rx_vld == 1'b0, int'(rx_vld), 0);
    chk("rst_busy", busy == 1'b0, int'(busy), 0);
    chk("rst_s_ready", s_ready == 1'b0, int'(s_ready), 0);
    chk("rst_pkt_done", pkt_done == 1'b0, int'(pkt_done), 0);
    chk("rst_trunc", trunc == 1'b0, int'(trunc), 0);
    chk("rst_underrun", underrun == 1'b0, int'(underrun), 0);
    chk("rst_pkt_cnt", pkt_cnt == 16'd0, int'(pkt_cnt), 0);

    rst = 1'b0;
    mon_en = 1'b1;
    en = 1'b1;
    tick();

    for (int v = 0; v < 14; v++) begin
      min_len = 10'(tbl[v].minl);
      max_len = 10'(tbl[v].maxl);
      fill_count(tbl[v].n);
      push_stream(tbl[v].drop);
      push_exp(tbl[v].exp_len, tbl[v].exp_tr, tbl[v].exp_un);
      wait_idle("table_timeout", 5000);
    end

    // Length inputs changed after the frame has latched its shadows.
    min_len = 10'd64;
    max_len = 10'd512;
    fill_count(10);
    push_stream(0);
    push_exp(64, 1'b0, 1'b0);
    k = 0;
    while (!busy && k < 100) begin tick(); k++; end
    chk("midlen_start", k < 100, k, 100);
    min_len = 10'd300;
    max_len = 10'd20;
    wait_idle("midlen_timeout", 3000);
    min_len = 10'd64;
    max_len = 10'd512;

    // en dropped mid-frame with the next packet already waiting on the stream.
    fill_count(100);
    push_stream(0);
    push_exp(102, 1'b0, 1'b0);
    fill_rand(30);
    push_stream(0);
    push_exp(64, 1'b0, 1'b0);
    k = 0;
    while (!busy && k < 100) begin tick(); k++; end
    en = 1'b0;
    k = 0;
    while (exp_desc.size() > 1 && k < 2000) begin tick(); k++; end
    chk("en_first_frame", k < 2000, k, 2000);
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    b0 = beat_cnt;
    repeat (30) tick();
    chk("en_low_no_busy", busy == 1'b0, int'(busy), 0);
    chk("en_low_no_beats", beat_cnt == b0, beat_cnt, b0);
    chk("en_low_no_ready", s_ready == 1'b0, int'(s_ready), 0);
    en = 1'b1;
    wait_idle("en_resume_timeout", 3000);

    // Randomized back-to-back batches with s_valid held high between packets.
    for (int b = 0; b < 6; b++) begin
      int ml;
      int xl;
      int smax;
      int n;
      int d;
      int len;
      int lim;
      bit tr;
      bit un;
      ml = $urandom_range(700, 0);
      xl = $urandom_range(1023, 8);
      smax = (xl > 512) ? 512 : xl;
      min_len = 10'(ml);
      max_len = 10'(xl);
      for (int p = 0; p < 4; p++) begin
        n = $urandom_range(600, 1);
        d = 0;
        lim = ((n - 1) < (smax - 3)) ? (n - 1) : (smax - 3);
        if (lim >= 1 && $urandom_range(9, 0) < 3) d = $urandom_range(lim, 1);
        fill_rand(n);
        push_stream(d);
        model(n, ml, xl, d, len, tr, un);
        push_exp(len, tr, un);
      end
      wait_idle("random_timeout", 20000);
    end

    // Reset in the middle of the payload.
    min_len = 10'd64;
    max_len = 10'd512;
    fill_rand(100);
    push_stream(0);
    push_exp(102, 1'b0, 1'b0);
    b0 = beat_cnt;
    k = 0;
    while (beat_cnt < b0 + 20 && k < 2000) begin tick(); k++; end
    chk("rst_reach_payload", k < 2000, k, 2000);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_rx_vld", rx_vld == 1'b0, int'(rx_vld), 0);
    chk("midrst_busy", busy == 1'b0, int'(busy), 0);
    chk("midrst_s_ready", s_ready == 1'b0, int'(s_ready), 0);
    chk("midrst_pkt_cnt", pkt_cnt == 16'd0, int'(pkt_cnt), 0);
    stream.delete();
    exp_desc.delete();
    exp_bytes.delete();
    got_q.delete();
    in_frame = 1'b0;
    frames_ended = 0;
    exp_cnt = 0;
    low_run = 0;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    fill_count(5);
    push_stream(0);
    push_exp(64, 1'b0, 1'b0);
    wait_idle("post_rst_timeout", 3000);

    chk("frames_outstanding", exp_desc.size() == 0, exp_desc.size(), 0);
    chk("rxd_zero_when_idle", rxd_nz_err == 0, rxd_nz_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_framer.md
Name: pkt_framer

Overview:
- Upstream neighbour of the packet switch core; drives that core's rxd/rx_vld receive input.
- Accepts payload bytes from a valid/ready byte stream and prepends the 2-byte header 0x55,0xD5.
- Pads short packets with 0x00 up to the minimum length, truncates long ones at the maximum length, and enforces an idle inter-packet gap so the downstream receiver returns to idle between packets.

Parameters:
- MAX_LEN, 512, absolute ceiling on total frame bytes (header included); 10-bit counters.
- MIN_LEN_FLOOR, 64, lower clamp applied to min_len.
- GAP_CYC, 4, rx_vld-low cycles between frames; must be >= 3.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  frame enable; sampled only in IDLE
- min_len  in  10  minimum total frame bytes, header included
- max_len  in  10  maximum total frame bytes, header included
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_last  in  1  last payload byte of packet
- s_ready  out  1  payload byte accepted when s_valid && s_ready
- rxd  out  8  framed byte to switch core
- rx_vld  out  1  framed byte valid
- busy  out  1  high in any state other than IDLE
- pkt_done  out  1  1-cycle pulse on the frame's final output byte
- trunc  out  1  1-cycle pulse when truncation occurs
- underrun  out  1  1-cycle pulse when a packet is aborted on underrun
- pkt_cnt  out  16  count of completed frames; wraps

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; FSM in IDLE; counters and shadow registers 0.
- rst asserted mid-frame: aborts immediately; rx_vld = 0 on the next cycle.
- Output timing: rxd/rx_vld/pkt_done/trunc/underrun are registered. An accepted beat appears on rxd exactly 1 cycle after acceptance.
- States: IDLE, HDR0, HDR1, PAYLOAD, PAD, DRAIN, GAP.
- IDLE:
  - s_ready = 0.
  - If en && s_valid, latch the shadow lengths and go to HDR0. No byte is consumed.
  - Shadow max = min(max_len, MAX_LEN).
  - Shadow min = max(min_len, MIN_LEN_FLOOR), then clamped to shadow max.
  - Byte counter cnt = 0.
- HDR0: emit 0x55; cnt = 1; go to HDR1.
- HDR1: emit 0xD5; cnt = 2; go to PAYLOAD. s_ready rises in this cycle so the first payload byte can be accepted.
- PAYLOAD:
  - s_ready = 1. Each accepted beat is emitted and increments cnt.
  - Accepted beat with s_last:
    - If cnt+1 < shadow min, go to PAD.
    - Otherwise pulse pkt_done with that byte and go to GAP.
  - Accepted beat without s_last where cnt+1 == shadow max: pulse pkt_done and trunc, then go to DRAIN.
  - s_last and the max boundary in the same beat: s_last wins; no trunc.
  - s_valid low: go to DRAIN, pulse underrun, rx_vld = 0 next cycle. The partial frame is not counted; no pkt_done.
- PAD:
  - s_ready = 0. Emit 0x00 and increment cnt each cycle.
  - pkt_done with the byte that makes cnt == shadow min, then go to GAP.
- DRAIN:
  - rx_vld = 0; s_ready = 1.
  - Discard beats until an accepted s_last, then go to GAP.
  - A beat with s_last accepted while still in PAYLOAD is never drained.
- GAP:
  - rx_vld = 0; s_ready = 0.
  - Count GAP_CYC cycles, then go to IDLE.
  - If en && s_valid, the next frame's HDR0 byte follows no earlier than GAP_CYC+1 cycles after the final byte.
- Enable and length inputs:
  - en deassert mid-frame has no effect until IDLE.
  - min_len/max_len changes mid-frame are ignored; shadows are used.
- pkt_cnt increments on every pkt_done, with or without trunc. It wraps 0xFFFF -> 0.
- rxd = 0x00 whenever rx_vld = 0.
- busy = (state != IDLE).
- Width rule: all length arithmetic is unsigned 10-bit; cnt never exceeds shadow max.

Decomposition:
- Shared package pkt_pkg:
  - HDR_B0 = 8'h55, HDR_B1 = 8'hD5.
  - Framer state typedef.
  - Default length constants 64/512, shared with the switch core's register defaults.
- No sub-module; a single always-block FSM with a datapath counter.

Test Plan:
- Payload of 100 bytes 0x01..0x64, min 64, max 512 -> 102-byte frame 55 D5 01..64; pkt_done on the last byte; pkt_cnt = 1; then 4 idle cycles.
- Payload of 10 bytes, min 64 -> 55 D5, 10 payload bytes, 52 × 0x00; total 64 bytes; no trunc.
- Payload of 600 bytes, max 512 -> 512 bytes out; trunc and pkt_done on byte 512. The remaining 90 bytes are accepted with rx_vld = 0 until s_last; pkt_cnt = 1.
- s_valid drops after 20 payload bytes -> underrun pulse; rx_vld low next cycle; framer drains to s_last; pkt_cnt unchanged.
- Boundary and length rules:
  - s_last exactly on byte 512 -> pkt_done, no trunc.
  - min_len = 10 -> clamped to 64.
  - min_len = 600, max_len = 512 -> shadow min = 512.
  - min_len changed mid-frame -> no effect on the current frame.
- Back-to-back packets with s_valid held high, plus en toggled low mid-frame -> current frame completes; at least 4 rx_vld-low cycles between frames; no new frame while en = 0. rst mid-PAYLOAD -> rx_vld = 0 and busy = 0 one cycle later.
